// File: rtl/ex_mem_latch_pkg.sv
// Shared widths and flag-bit layout for the EX/MEM pipeline latch.
package ex_mem_latch_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned FW = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_O = 0;

  // Packs individual ALU flags into the architectural {n,z,c,o} layout.
  function automatic logic [FW-1:0] pack_flags(input logic n, input logic z,
                                               input logic c, input logic o);
    logic [FW-1:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_O] = o;
    return f;
  endfunction

endpackage

// File: rtl/ex_mem_latch_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM latch; the EX stage is master.
interface ex_mem_latch_if #(
  parameter int unsigned DW = ex_mem_latch_pkg::DW,
  parameter int unsigned RW = ex_mem_latch_pkg::RW
);
  logic          exValid;
  logic [DW-1:0] busALU;
  logic          zALU;
  logic          nALU;
  logic          cALU;
  logic          oALU;
  logic [DW-1:0] busB;
  logic [RW-1:0] rdEX;
  logic          regWrEX;
  logic          memRdEX;
  logic          memWrEX;
  logic          setFlagsEX;
  logic          stall;
  logic          flush;
  logic          clrSticky;

  logic          memValid;
  logic [DW-1:0] busMEM;
  logic [DW-1:0] busStore;
  logic [RW-1:0] rdMEM;
  logic          regWrMEM;
  logic          memRdMEM;
  logic          memWrMEM;
  logic [3:0]    flags;
  logic          stickyO;
  logic          fwdValid;

  modport master (
    output exValid, busALU, zALU, nALU, cALU, oALU, busB, rdEX,
           regWrEX, memRdEX, memWrEX, setFlagsEX, stall, flush, clrSticky,
    input  memValid, busMEM, busStore, rdMEM, regWrMEM, memRdMEM, memWrMEM,
           flags, stickyO, fwdValid
  );

  modport slave (
    input  exValid, busALU, zALU, nALU, cALU, oALU, busB, rdEX,
           regWrEX, memRdEX, memWrEX, setFlagsEX, stall, flush, clrSticky,
    output memValid, busMEM, busStore, rdMEM, regWrMEM, memRdMEM, memWrMEM,
           flags, stickyO, fwdValid
  );
endinterface

// File: rtl/ex_mem_latch_flag_reg.sv
// Architectural {n,z,c,o} flag register plus the sticky overflow bit.
module flag_reg
  import ex_mem_latch_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          commit_i,
  input  logic          n_i,
  input  logic          z_i,
  input  logic          c_i,
  input  logic          o_i,
  input  logic          clr_sticky_i,
  output logic [FW-1:0] flags_o,
  output logic          sticky_o
);

  logic [FW-1:0] flags_d, flags_q;
  logic          sticky_d, sticky_q;

  // A committed overflow takes priority over a coincident clear.
  always_comb begin
    flags_d  = flags_q;
    sticky_d = sticky_q;
    if (clr_sticky_i) sticky_d = 1'b0;
    if (commit_i) begin
      flags_d = pack_flags(n_i, z_i, c_i, o_i);
      if (o_i) sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
    end
  end

  assign flags_o  = flags_q;
  assign sticky_o = sticky_q;

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with stall/flush control and the architectural flag state.
module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int unsigned DW = ex_mem_latch_pkg::DW,
  parameter int unsigned RW = ex_mem_latch_pkg::RW
) (
  input logic            clk,
  input logic            reset,
  ex_mem_latch_if.slave  bus
);

  logic          valid_d, valid_q;
  logic [DW-1:0] res_d, res_q;
  logic [DW-1:0] store_d, store_q;
  logic [RW-1:0] rd_d, rd_q;
  logic          regwr_d, regwr_q;
  logic          memrd_d, memrd_q;
  logic          memwr_d, memwr_q;

  logic          load_c;
  logic          commit_c;
  logic          clr_c;
  logic [FW-1:0] flags_w;
  logic          sticky_w;

  assign load_c   = !bus.stall && !bus.flush;
  assign commit_c = load_c && bus.exValid && bus.setFlagsEX;
  // A plain stall freezes the sticky bit as well.
  assign clr_c    = bus.clrSticky && !(bus.stall && !bus.flush);

  // Flush drops the instruction but leaves data fields as they were.
  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    store_d = store_q;
    rd_d    = rd_q;
    regwr_d = regwr_q;
    memrd_d = memrd_q;
    memwr_d = memwr_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
      memrd_d = 1'b0;
      memwr_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d = bus.exValid;
      res_d   = bus.busALU;
      store_d = bus.busB;
      rd_d    = bus.rdEX;
      regwr_d = bus.exValid && bus.regWrEX;
      memrd_d = bus.exValid && bus.memRdEX;
      memwr_d = bus.exValid && bus.memWrEX;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      store_q <= '0;
      rd_q    <= '0;
      regwr_q <= 1'b0;
      memrd_q <= 1'b0;
      memwr_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      store_q <= store_d;
      rd_q    <= rd_d;
      regwr_q <= regwr_d;
      memrd_q <= memrd_d;
      memwr_q <= memwr_d;
    end
  end

  flag_reg u_flag_reg (
    .clk          (clk),
    .reset        (reset),
    .commit_i     (commit_c),
    .n_i          (bus.nALU),
    .z_i          (bus.zALU),
    .c_i          (bus.cALU),
    .o_i          (bus.oALU),
    .clr_sticky_i (clr_c),
    .flags_o      (flags_w),
    .sticky_o     (sticky_w)
  );

  assign bus.memValid = valid_q;
  assign bus.busMEM   = res_q;
  assign bus.busStore = store_q;
  assign bus.rdMEM    = rd_q;
  assign bus.regWrMEM = valid_q && regwr_q;
  assign bus.memRdMEM = valid_q && memrd_q;
  assign bus.memWrMEM = valid_q && memwr_q;
  assign bus.flags    = flags_w;
  assign bus.stickyO  = sticky_w;
  assign bus.fwdValid = valid_q && regwr_q && (rd_q != '0);

endmodule

// File: tb/tb_ex_mem_latch.sv
// Directed-vector bench for ex_mem_latch with hand-computed expectations.
module tb_ex_mem_latch;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  ex_mem_latch_if #(.DW(32), .RW(5)) bus ();

  ex_mem_latch #(.DW(32), .RW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.exValid    = 1'b0;
    bus.busALU     = '0;
    bus.zALU       = 1'b0;
    bus.nALU       = 1'b0;
    bus.cALU       = 1'b0;
    bus.oALU       = 1'b0;
    bus.busB       = '0;
    bus.rdEX       = '0;
    bus.regWrEX    = 1'b0;
    bus.memRdEX    = 1'b0;
    bus.memWrEX    = 1'b0;
    bus.setFlagsEX = 1'b0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
    bus.clrSticky  = 1'b0;
  endtask

  task automatic set_flags_in(input logic n, input logic z, input logic c, input logic o);
    bus.nALU = n;
    bus.zALU = z;
    bus.cALU = c;
    bus.oALU = o;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    chk("rst_valid",  32'(bus.memValid), 32'd0);
    chk("rst_bus",    bus.busMEM,        32'd0);
    chk("rst_flags",  32'(bus.flags),    32'd0);
    chk("rst_sticky", 32'(bus.stickyO),  32'd0);
    chk("rst_fwd",    32'(bus.fwdValid), 32'd0);

    // Shift-result commit with carry and overflow
    reset          = 1'b0;
    bus.exValid    = 1'b1;
    bus.busALU     = 32'h0000_0002;
    bus.busB       = 32'h0000_0055;
    bus.rdEX       = 5'd3;
    bus.regWrEX    = 1'b1;
    bus.memRdEX    = 1'b1;
    bus.setFlagsEX = 1'b1;
    set_flags_in(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    chk("shf_bus",    bus.busMEM,        32'h2);
    chk("shf_flags",  32'(bus.flags),    32'h3);
    chk("shf_sticky", 32'(bus.stickyO),  32'd1);
    chk("shf_valid",  32'(bus.memValid), 32'd1);
    chk("shf_store",  bus.busStore,      32'h55);
    chk("shf_rd",     32'(bus.rdMEM),    32'd3);
    chk("shf_memrd",  32'(bus.memRdMEM), 32'd1);
    chk("shf_fwd",    32'(bus.fwdValid), 32'd1);

    // Stall hold
    bus.memRdEX    = 1'b0;
    bus.setFlagsEX = 1'b0;
    bus.busALU     = 32'hDEAD_BEEF;
    step();
    chk("ld_bus", bus.busMEM, 32'hDEAD_BEEF);
    bus.stall      = 1'b1;
    bus.busALU     = '0;
    bus.setFlagsEX = 1'b1;
    set_flags_in(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_bus",   bus.busMEM,     32'hDEAD_BEEF);
      chk("stl_flags", 32'(bus.flags), 32'h3);
    end

    // Stall plus flush: flush wins, data fields keep old values
    bus.flush   = 1'b1;
    bus.regWrEX = 1'b1;
    bus.rdEX    = 5'd5;
    step();
    chk("fl_valid", 32'(bus.memValid), 32'd0);
    chk("fl_regwr", 32'(bus.regWrMEM), 32'd0);
    chk("fl_fwd",   32'(bus.fwdValid), 32'd0);
    chk("fl_flags", 32'(bus.flags),    32'h3);
    chk("fl_bus",   bus.busMEM,        32'hDEAD_BEEF);
    chk("fl_rd",    32'(bus.rdMEM),    32'd3);

    // Bubble never writes anything
    bus.stall   = 1'b0;
    bus.flush   = 1'b0;
    bus.exValid = 1'b0;
    bus.memWrEX = 1'b1;
    step();
    chk("bub_valid", 32'(bus.memValid), 32'd0);
    chk("bub_memwr", 32'(bus.memWrMEM), 32'd0);
    chk("bub_regwr", 32'(bus.regWrMEM), 32'd0);
    chk("bub_flags", 32'(bus.flags),    32'h3);

    // Sticky priority
    bus.exValid   = 1'b1;
    bus.memWrEX   = 1'b0;
    bus.clrSticky = 1'b1;
    set_flags_in(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("stk_clr",   32'(bus.stickyO), 32'd0);
    chk("stk_flag0", 32'(bus.flags),   32'h0);
    set_flags_in(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("stk_set",   32'(bus.stickyO), 32'd1);
    chk("stk_flag1", 32'(bus.flags),   32'h1);

    // Zero flag and forwarding qualification on rd
    bus.clrSticky = 1'b0;
    bus.busALU    = '0;
    bus.rdEX      = 5'd0;
    set_flags_in(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("z_flags", 32'(bus.flags),    32'h4);
    chk("z_fwd0",  32'(bus.fwdValid), 32'd0);
    bus.rdEX = 5'd7;
    step();
    chk("z_fwd7",  32'(bus.fwdValid), 32'd1);
    chk("z_rd",    32'(bus.rdMEM),    32'd7);

    // Overflow without setFlags does not touch sticky
    bus.clrSticky  = 1'b1;
    bus.setFlagsEX = 1'b0;
    step();
    chk("nc_clr", 32'(bus.stickyO), 32'd0);
    bus.clrSticky = 1'b0;
    set_flags_in(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk("nc_sticky", 32'(bus.stickyO), 32'd0);
    chk("nc_flags",  32'(bus.flags),   32'h4);

    // Mid-operation reset
    bus.setFlagsEX = 1'b1;
    set_flags_in(1'b1, 1'b1, 1'b1, 1'b1);
    bus.busALU = 32'h0000_00AA;
    step();
    chk("pre_flags", 32'(bus.flags),    32'hF);
    chk("pre_valid", 32'(bus.memValid), 32'd1);
    reset     = 1'b1;
    bus.stall = 1'b1;
    step();
    chk("mr_valid",  32'(bus.memValid), 32'd0);
    chk("mr_bus",    bus.busMEM,        32'd0);
    chk("mr_store",  bus.busStore,      32'd0);
    chk("mr_rd",     32'(bus.rdMEM),    32'd0);
    chk("mr_flags",  32'(bus.flags),    32'd0);
    chk("mr_sticky", 32'(bus.stickyO),  32'd0);
    chk("mr_fwd",    32'(bus.fwdValid), 32'd0);
    reset          = 1'b0;
    bus.stall      = 1'b0;
    bus.setFlagsEX = 1'b0;
    bus.busALU     = 32'h0000_1234;
    step();
    chk("post_bus",   bus.busMEM,        32'h1234);
    chk("post_valid", 32'(bus.memValid), 32'd1);
    chk("post_flags", 32'(bus.flags),    32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
